// File: rtl/pwm_spi_host.sv
// -----------------------------------------------------------------------------
// pwm_spi_host
//   SPI initiator (mode 0, MSB first) that turns one accepted command into one
//   16-bit frame for the PWM peripheral: an instruction byte {write, 0, addr}
//   followed by a data byte (write data, or 8'h00 while reading miso).
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   cmd_valid/ready command handshake (ready only while IDLE and not in reset)
//   cmd_write       1 = register write, 0 = register read
//   cmd_addr        6-bit register address
//   cmd_wdata       write data (ignored for reads)
//   rsp_valid       one-cycle pulse when a frame completes
//   rsp_rdata       read data (8'h00 after a write), held until next rsp_valid
//   busy            frame in progress, including the post-frame gap
//   sclk/cs_n/mosi  SPI outputs (sclk idles low, cs_n active low)
//   miso            SPI input from the peripheral
// -----------------------------------------------------------------------------
module pwm_spi_host #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  // One shared phase counter serves every timed phase, so it is sized for the
  // longest of them and cleared at each phase boundary.
  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
  localparam int CNT_MAX = ((MAX_A > MAX_B) ? MAX_A : MAX_B) - 1;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [3:0]       r_bit, w_bit;
  logic [15:0]      r_shreg, w_shreg;
  logic [7:0]       r_rx, w_rx;
  logic             r_sclk, w_sclk;
  logic             r_cs_n, w_cs_n;
  logic             r_mosi, w_mosi;
  logic             r_rsp_valid, w_rsp_valid;
  logic [7:0]       r_rsp_rdata, w_rsp_rdata;
  logic             w_accept;

  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign busy      = (r_state != S_IDLE);
  assign sclk      = r_sclk;
  assign cs_n      = r_cs_n;
  assign mosi      = r_mosi;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_bit       = r_bit;
    w_shreg     = r_shreg;
    w_rx        = r_rx;
    w_sclk      = r_sclk;
    w_cs_n      = r_cs_n;
    w_mosi      = r_mosi;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;

    case (r_state)
      S_IDLE: begin
        w_cs_n = 1'b1;
        w_sclk = 1'b0;
        if (w_accept) begin
          w_shreg = {cmd_write, 1'b0, cmd_addr, (cmd_write ? cmd_wdata : 8'h00)};
          w_mosi  = cmd_write;  // bit 15 of the frame
          w_cs_n  = 1'b0;
          w_cnt   = '0;
          w_state = S_SETUP;
        end
      end

      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          // First rising edge of sclk; miso is sampled on every 0->1 edge.
          w_state = S_SHIFT;
          w_cnt   = '0;
          w_bit   = 4'd15;
          w_sclk  = 1'b1;
          w_rx    = {r_rx[6:0], miso};
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_SHIFT: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt = '0;
          if (r_sclk) begin
            // Falling edge: the only place mosi moves. After bit 0 it parks low.
            w_sclk = 1'b0;
            w_mosi = (r_bit == 4'd0) ? 1'b0 : r_shreg[r_bit - 4'd1];
          end else if (r_bit == 4'd0) begin
            w_state = S_HOLD;
          end else begin
            w_sclk = 1'b1;
            w_bit  = r_bit - 4'd1;
            w_rx   = {r_rx[6:0], miso};
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          // After 16 samples r_rx holds exactly the second (data) byte.
          w_state     = S_GAP;
          w_cnt       = '0;
          w_cs_n      = 1'b1;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_shreg[15] ? 8'h00 : r_rx;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_bit       <= w_bit;
      r_sclk      <= w_sclk;
      r_cs_n      <= w_cs_n;
      r_mosi      <= w_mosi;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  // Frame and receive shifters carry data only; their contents are always
  // rewritten before use, so they need no reset.
  always_ff @(posedge clk) begin
    r_shreg <= w_shreg;
    r_rx    <= w_rx;
  end

endmodule

// File: tb/tb_pwm_spi_host.sv
// -----------------------------------------------------------------------------
// tb_pwm_spi_host
//   Two instances: index 0 with CLK_DIV=4, index 1 with CLK_DIV=1 (other timing
//   parameters at 2). A slave model per instance serves a queued byte on miso
//   during the data byte; a monitor per instance rebuilds each frame from the
//   pins and checks it against a scoreboard filled by the command driver.
// -----------------------------------------------------------------------------
module tb_pwm_spi_host;

  localparam int NDUT  = 2;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int GAP   = 2;

  typedef struct packed {
    logic [15:0] frame;
    logic [7:0]  rdata;
    logic [31:0] acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       cmd_valid [NDUT];
  logic       cmd_ready [NDUT];
  logic       cmd_write [NDUT];
  logic [5:0] cmd_addr  [NDUT];
  logic [7:0] cmd_wdata [NDUT];
  logic       rsp_valid [NDUT];
  logic [7:0] rsp_rdata [NDUT];
  logic       busy      [NDUT];
  logic       sclk      [NDUT];
  logic       cs_n      [NDUT];
  logic       mosi      [NDUT];
  logic       miso      [NDUT];

  exp_t       exp_q [NDUT][$];
  logic [7:0] slv_q [NDUT][$];
  bit         sticky_bad [NDUT];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference frame: instruction byte {write, 0, addr}, then data or 0x00.
  function automatic logic [15:0] model_frame(input logic w, input logic [5:0] a,
                                              input logic [7:0] wd);
    logic [7:0] instr;
    logic [7:0] data;
    instr = {w, 1'b0, a};
    data  = w ? wd : 8'h00;
    return {instr, data};
  endfunction

  // Slave presents bit (15 - n) of {junk, response} before the n-th rising edge.
  function automatic logic slave_bit(input logic [7:0] j, input logic [7:0] r,
                                     input logic [4:0] n, input logic csn);
    logic [15:0] word;
    word = {j, r};
    if (csn || n > 5'd15) return 1'b0;
    return word[4'(5'd15 - n)];
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 4 : 1;
    logic [7:0] junk  = 8'h00;
    logic [7:0] resp  = 8'h00;
    logic [4:0] rises = 5'd0;

    pwm_spi_host #(
      .CLK_DIV (DIV),
      .CS_SETUP(SETUP),
      .CS_HOLD (HOLD),
      .IDLE_GAP(GAP)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid[g]),
      .cmd_ready(cmd_ready[g]),
      .cmd_write(cmd_write[g]),
      .cmd_addr (cmd_addr[g]),
      .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g]),
      .sclk     (sclk[g]),
      .cs_n     (cs_n[g]),
      .mosi     (mosi[g]),
      .miso     (miso[g])
    );

    assign miso[g] = slave_bit(junk, resp, rises, cs_n[g]);

    initial begin : mon
      logic [15:0] cap;
      logic [7:0]  last_rd;
      int          low_cnt, high_cnt, last_rise, hi_run;
      bit          prev_cs, prev_sclk, prev_mosi, prev_rv, frame_bad, gap_ok, fstart;
      exp_t        e;
      cap = '0; last_rd = 8'h00; low_cnt = 0; high_cnt = 1000; last_rise = 0; hi_run = 0;
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_rv = 1'b0;
      frame_bad = 1'b0; gap_ok = 1'b1; fstart = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          exp_q[g].delete();
          slv_q[g].delete();
          prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_rv = 1'b0;
          high_cnt = 1000; rises = 5'd0; last_rd = 8'h00; frame_bad = 1'b0;
        end else begin
          fstart = !cs_n[g] && prev_cs;
          if (!cs_n[g]) begin
            if (fstart) begin
              low_cnt = 0; rises = 5'd0; cap = '0; frame_bad = 1'b0; hi_run = 0;
              gap_ok = (high_cnt >= GAP);
              resp = (slv_q[g].size() != 0) ? slv_q[g].pop_front() : 8'h00;
              junk = 8'($urandom);
            end
            low_cnt++;
            high_cnt = 0;
            if (sclk[g] && !prev_sclk) begin
              if (rises == 5'd0) begin
                if (low_cnt != SETUP + 1) frame_bad = 1'b1;
              end else if (low_cnt - last_rise != 2 * DIV) begin
                frame_bad = 1'b1;
              end
              last_rise = low_cnt;
              rises++;
              cap = {cap[14:0], mosi[g]};
            end
            if (sclk[g]) hi_run++;
            if (prev_sclk && !sclk[g]) begin
              if (hi_run != DIV) frame_bad = 1'b1;
              hi_run = 0;
            end
            if (!fstart && (mosi[g] != prev_mosi) && !(prev_sclk && !sclk[g]))
              frame_bad = 1'b1;
          end else begin
            high_cnt++;
            if (sclk[g] || mosi[g]) sticky_bad[g] = 1'b1;
          end

          if (cmd_ready[g] == busy[g]) sticky_bad[g] = 1'b1;
          if (!rsp_valid[g] && (rsp_rdata[g] != last_rd)) sticky_bad[g] = 1'b1;

          if (rsp_valid[g]) begin
            if (prev_rv) sticky_bad[g] = 1'b1;
            last_rd = rsp_rdata[g];
            if (exp_q[g].size() == 0) begin
              chk($sformatf("rsp_unexpected[%0d]", g), 32'd1, 32'd0);
            end else begin
              e = exp_q[g].pop_front();
              chk($sformatf("frame[%0d]", g),   32'(cap),           32'(e.frame));
              chk($sformatf("rises[%0d]", g),   32'(rises),         32'd16);
              chk($sformatf("cs_low[%0d]", g),  32'(low_cnt),       32'(SETUP + 32 * DIV + HOLD));
              chk($sformatf("latency[%0d]", g), 32'(cyc) - e.acc,   32'(1 + SETUP + 32 * DIV + HOLD));
              chk($sformatf("rdata[%0d]", g),   32'(rsp_rdata[g]),  32'(e.rdata));
              chk($sformatf("pin_timing[%0d]", g), 32'(frame_bad),  32'd0);
              chk($sformatf("cs_gap[%0d]", g),  32'(gap_ok),        32'd1);
            end
          end
          prev_cs   = cs_n[g];
          prev_sclk = sclk[g];
          prev_mosi = mosi[g];
          prev_rv   = rsp_valid[g];
        end
      end
    end
  end

  task automatic send(input int d, input logic w, input logic [5:0] a, input logic [7:0] wd,
                      input logic [7:0] sr, input bit keep);
    exp_t e;
    int   t;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b1;
    cmd_write[d] = w;
    cmd_addr[d]  = a;
    cmd_wdata[d] = wd;
    t = 0;
    @(negedge clk);
    while (!cmd_ready[d] && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (!cmd_ready[d]) begin
      chk($sformatf("accept_timeout[%0d]", d), 32'd0, 32'd1);
      cmd_valid[d] = 1'b0;
      return;
    end
    e.frame = model_frame(w, a, wd);
    e.rdata = w ? 8'h00 : sr;
    e.acc   = 32'(cyc);
    exp_q[d].push_back(e);
    slv_q[d].push_back(sr);
    @(posedge clk); #1;
    if (!keep) begin
      cmd_valid[d] = 1'b0;
      cmd_write[d] = 1'($urandom);
      cmd_addr[d]  = 6'($urandom);
      cmd_wdata[d] = 8'($urandom);
    end
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while ((busy[d] || exp_q[d].size() != 0) && t < 3000) begin
      @(posedge clk); #1;
      cmd_write[d] = 1'($urandom);
      cmd_addr[d]  = 6'($urandom);
      cmd_wdata[d] = 8'($urandom);
      @(negedge clk);
      t++;
    end
    chk($sformatf("idle_reached[%0d]", d), 32'(!busy[d] && exp_q[d].size() == 0), 32'd1);
  endtask

  task automatic rand_cmd(input int d, input bit keep);
    send(d, 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), keep);
  endtask

  initial begin : main
    int rv_seen;
    for (int d = 0; d < NDUT; d++) begin
      cmd_valid[d] = 1'b0; cmd_write[d] = 1'b0; cmd_addr[d] = 6'h00; cmd_wdata[d] = 8'h00;
      sticky_bad[d] = 1'b0;
    end

    // Power-on reset: three cycles.
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk($sformatf("ready_in_rst[%0d]", d), 32'(cmd_ready[d]), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_ready[%0d]", d), 32'(cmd_ready[d]), 32'd1);
      chk($sformatf("rst_busy[%0d]", d),  32'(busy[d]),      32'd0);
      chk($sformatf("rst_cs_n[%0d]", d),  32'(cs_n[d]),      32'd1);
      chk($sformatf("rst_sclk[%0d]", d),  32'(sclk[d]),      32'd0);
      chk($sformatf("rst_mosi[%0d]", d),  32'(mosi[d]),      32'd0);
      chk($sformatf("rst_rspv[%0d]", d),  32'(rsp_valid[d]), 32'd0);
      chk($sformatf("rst_rdata[%0d]", d), 32'(rsp_rdata[d]), 32'd0);
    end

    for (int d = 0; d < NDUT; d++) begin
      send(d, 1'b1, 6'h02, 8'hA5, 8'h00, 1'b0);
      wait_idle(d);
      send(d, 1'b0, 6'h00, 8'h77, 8'h3C, 1'b0);
      wait_idle(d);
      // Back-to-back with cmd_valid held: second command's fields are on the
      // bus for the whole of the first frame.
      send(d, 1'b1, 6'h15, 8'h5A, 8'hFF, 1'b1);
      send(d, 1'b0, 6'h2B, 8'h00, 8'h96, 1'b0);
      wait_idle(d);
      for (int i = 0; i < 6; i++) rand_cmd(d, (i < 5) ? 1'($urandom) : 1'b0);
      wait_idle(d);
    end

    // Abort mid-SHIFT on instance 0 after leaving non-zero read data behind.
    send(0, 1'b0, 6'h11, 8'h00, 8'hC3, 1'b0);
    wait_idle(0);
    send(0, 1'b1, 6'h07, 8'h81, 8'h00, 1'b0);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cs_n",  32'(cs_n[0]),      32'd1);
    chk("abort_sclk",  32'(sclk[0]),      32'd0);
    chk("abort_mosi",  32'(mosi[0]),      32'd0);
    chk("abort_rdata", 32'(rsp_rdata[0]), 32'd0);
    chk("abort_busy",  32'(busy[0]),      32'd0);
    chk("abort_ready", 32'(cmd_ready[0]), 32'd0);
    chk("abort_rspv",  32'(rsp_valid[0]), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(cmd_ready[0]), 32'd1);
    rv_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) rv_seen++;
    end
    chk("abort_no_rsp", 32'(rv_seen), 32'd0);

    rand_cmd(0, 1'b0);
    wait_idle(0);

    repeat (5) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("pin_invariants[%0d]", d), 32'(sticky_bad[d]), 32'd0);
      chk($sformatf("sb_drained[%0d]", d), 32'(exp_q[d].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
